uart_tx_port: RTL and testbench
===============================

Name: uart_tx_port

Overview:
- Peripheral-side responder for the CPU's I/O write channel.
- Accepts a one-cycle byte write (w_req/w_data) from the execute stage, serialises it as 8N1 UART on txd, and reports w_busy.
- The CPU reads w_busy through its I/O status read at imm=0.
- Sits between the core and the board TX pin, next to the receive peripheral that feeds r_data.

Parameters:
- CLKS_PER_BIT, 234, clock cycles per UART bit (27 MHz / 115200). Must be >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous and active-low.
- w_req  in  1  write request, single-cycle pulse from the core.
- w_data  in  8  byte to transmit; sampled only when a request is accepted.
- w_busy  out  1  registered; 1 while a frame is in flight.
- txd  out  1  registered serial line, idle high.

Behaviour:
- Reset values (async, on rst_n=0): txd=1, w_busy=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- Acceptance:
  - w_req is accepted only in a cycle where w_busy==0 (state IDLE).
  - On accept: latch w_data into the shift register, clear the baud counter, state->START.
  - w_busy=1 and txd=0 from the next cycle onward.
- w_req while w_busy==1: ignored entirely. No queueing, no corruption of the frame in flight, no error flag.
- States IDLE, START, DATA, STOP (plus PARITY with the option below):
  - START: txd=0 for CLKS_PER_BIT cycles, then ->DATA with bit index 0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles; then shift right and increment the index. After index 7 completes, ->STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then ->IDLE. w_busy drops in the same edge.
- Baud counter: 0..CLKS_PER_BIT-1. It wraps to 0 at each bit boundary, and the state/bit advance happens on the wrap.
- Bit order: LSB first.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the first txd=0 cycle to the first cycle with w_busy=0.
- Back-to-back: a w_req in the first cycle with w_busy==0 is accepted, and its start bit immediately follows the previous stop bit. Minimum gap is zero idle bit times.
- Reset mid-frame: txd returns to 1 and w_busy to 0 asynchronously. The partial frame is abandoned and no resume occurs.
- Outputs are glitch-free: txd and w_busy are flop outputs only.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - txd = even parity (XOR of the 8 data bits, computed at accept time) for CLKS_PER_BIT cycles.
  - Frame becomes 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, no parity register; 8N1 as above.

Decomposition:
- Package lib_uart holds:
  - typedef enum logic [2:0] UART_TX_STATE {IDLE, START, DATA, PARITY, STOP}.
  - Constant UART_DATA_BITS = 8.
  - Function fn_parity(input logic [7:0]) returning the even-parity bit.
- One natural sub-module: uart_baud_cnt.
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clk, rst_n, clear.
  - Output: a one-cycle tick pulse at the bit boundary.
  - Shared later with the receiver.
- The FSM and shift register stay in uart_tx_port.

Test Plan (CLKS_PER_BIT=4):
- Reset release, no w_req for 50 cycles -> txd=1, w_busy=0 throughout.
- Single send of 0x55:
  - Single w_req pulse -> w_busy=1 next cycle for exactly 40 cycles.
  - txd sampled at each bit midpoint = 0,1,0,1,0,1,0,1,0,1 (start, LSB..MSB, stop).
- w_req with 0xA3, then w_req with 0xFF 10 cycles later while busy -> serialised data is 0xA3 only. The bits decode to 1,1,0,0,0,1,0,1, and w_busy stays high exactly 40 cycles (second request dropped).
- Back-to-back sends:
  - Send 0x01, then assert w_req with 0x80 in the first cycle w_busy==0.
  - Start bit of 0x80 begins the following cycle, with no idle-high gap beyond the stop bit.
  - Total of 80 busy cycles minus the 1 accept cycle.
- Reset mid-frame:
  - Send 0x00 and pull rst_n low in cycle 15 -> txd=1 and w_busy=0 immediately, without a clock edge.
  - After release, a fresh w_req with 0x3C transmits correctly.
- With UART_TX_PARITY_EN:
  - 0x07 -> parity bit 1 and frame length 44 cycles.
  - 0x03 -> parity bit 0.

Source files
------------

// File: rtl/lib_uart_pkg.sv
// Shared UART definitions: transmit FSM states, data width and the even-parity helper.
// The PARITY state is only reached when UART_TX_PARITY_EN is defined.
package lib_uart;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } UART_TX_STATE;

    localparam int UART_DATA_BITS = 8;

    function automatic logic fn_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
// Holding clear keeps it parked at 0 so the first bit after a clear is a full period.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST) && !clear;

    // Wrap on the boundary so consecutive bits are back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_port.sv
// UART transmit port for the CPU I/O write channel: 8N1 framing, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_port
    import lib_uart::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       w_req,
    input  logic [7:0] w_data,
    output logic       w_busy,
    output logic       txd
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    UART_TX_STATE state, state_next;
    logic [7:0]   shift, shift_next;
    logic [2:0]   bit_idx, bit_idx_next;
    logic         txd_next;
    logic         busy_next;
    logic         baud_clear;
    logic         baud_tick;
`ifdef UART_TX_PARITY_EN
    logic         parity_bit, parity_next;
`endif

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(baud_clear),
        .tick (baud_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            txd     <= 1'b1;
            w_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bit_idx <= bit_idx_next;
            txd     <= txd_next;
            w_busy  <= busy_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

    // txd is computed one cycle ahead so the line level changes on the same edge as the state.
    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        txd_next     = txd;
        busy_next    = w_busy;
        baud_clear   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_bit;
`endif
        case (state)
            IDLE: begin
                baud_clear = 1'b1;
                txd_next   = 1'b1;
                busy_next  = 1'b0;
                if (w_req) begin
                    shift_next = w_data;
                    state_next = START;
                    txd_next   = 1'b0;
                    busy_next  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_next = fn_parity(w_data);
`endif
                end
            end
            START: begin
                if (baud_tick) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    txd_next     = shift[0];
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        txd_next   = parity_bit;
`else
                        state_next = STOP;
                        txd_next   = 1'b1;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        txd_next     = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_next = STOP;
                    txd_next   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    state_next = IDLE;
                    txd_next   = 1'b1;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboard bench for uart_tx_port with CLKS_PER_BIT=4; a line monitor decodes frames.
// Honours UART_TX_PARITY_EN to expect the extra parity bit.
module tb_uart_tx_port;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * N;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       w_req;
    logic [7:0] w_data;
    logic       w_busy;
    logic       txd;

    int check_count = 0;
    int pass_count  = 0;
    int cyc_count   = 0;
    int next_free   = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    logic       in_frame = 1'b0;
    int         f_start  = 0;
    logic       samples[NBITS];

    uart_tx_port #(
        .CLKS_PER_BIT(N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .w_req (w_req),
        .w_data(w_data),
        .w_busy(w_busy),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_count <= cyc_count + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        check_count++;
        if (act == exp) pass_count++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drives one request pulse from a negedge; the model decides whether the port is free.
    task automatic applyStimulus(input logic [7:0] d);
        int upcoming;
        w_req    = 1'b1;
        w_data   = d;
        upcoming = cyc_count + 1;
        if (upcoming >= next_free) begin
            exp_q.push_back(d);
            next_free = upcoming + FRAME + 1;
        end
        @(negedge clk);
        w_req  = 1'b0;
        w_data = 8'($urandom);
    endtask

    task automatic waitIdle();
        while (cyc_count + 1 < next_free) @(negedge clk);
    endtask

    task automatic finishFrame();
        logic [7:0] exp_byte;
        logic [7:0] got;
        if (exp_q.size() == 0) begin
            checkOutput("unexpected_frame", 1, 0);
        end else begin
            exp_byte = exp_q.pop_front();
            for (int i = 0; i < 8; i++) got[i] = samples[i + 1];
            checkOutput("start_bit", int'(samples[0]), 0);
            checkOutput("data_byte", int'(got), int'(exp_byte));
`ifdef UART_TX_PARITY_EN
            checkOutput("parity_bit", int'(samples[9]), int'(^exp_byte));
`endif
            checkOutput("stop_bit", int'(samples[NBITS - 1]), 1);
        end
    endtask

    // Line monitor: frame begins at the first txd=0 cycle and ends when w_busy drops.
    always @(negedge clk) begin
        int off;
        if (!rst_n) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (txd == 1'b0) begin
                in_frame = 1'b1;
                f_start  = cyc_count;
                start_q.push_back(cyc_count);
                checkOutput("busy_at_start", int'(w_busy), 1);
            end else begin
                checkOutput("idle_busy", int'(w_busy), 0);
            end
        end else begin
            off = cyc_count - f_start;
            if ((off % N) == (N / 2) && (off / N) < NBITS) samples[off / N] = txd;
            if (!w_busy) begin
                checkOutput("frame_length", off, FRAME);
                finishFrame();
                in_frame = 1'b0;
            end else if (off > FRAME + 4) begin
                checkOutput("frame_timeout", off, FRAME);
                in_frame = 1'b0;
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        w_req  = 1'b0;
        w_data = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_txd", int'(txd), 1);
        checkOutput("reset_busy", int'(w_busy), 0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        checkOutput("idle_txd", int'(txd), 1);

        applyStimulus(8'h55);
        waitIdle();

        applyStimulus(8'hA3);
        repeat (9) @(negedge clk);
        applyStimulus(8'hFF);
        waitIdle();

        applyStimulus(8'h01);
        waitIdle();
        applyStimulus(8'h80);
        waitIdle();
        @(negedge clk);
        if (start_q.size() >= 2)
            checkOutput("b2b_gap", start_q[$] - start_q[$-1], FRAME + 1);
        else
            checkOutput("b2b_frames_seen", start_q.size(), 2);

        applyStimulus(8'h00);
        repeat (14) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_txd", int'(txd), 1);
        checkOutput("async_reset_busy", int'(w_busy), 0);
        exp_q.delete();
        next_free = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus(8'h3C);
        waitIdle();

`ifdef UART_TX_PARITY_EN
        applyStimulus(8'h07);
        waitIdle();
        applyStimulus(8'h03);
        waitIdle();
`endif

        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            applyStimulus(8'($urandom));
        end
        waitIdle();
        repeat (5) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
